// File: rtl/float_normalizer.sv
// Post-add normalization stage: renormalizes the adder magnitude one left shift
// per cycle, then packs an IEEE-754 single word behind valid/ready handshakes.
module float_normalizer #(
   parameter int MANT_W = 24,
   parameter int EXP_W  = 8
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_valid,
   output logic                    o_ready,
   input  logic                    i_sign,
   input  logic [EXP_W-1:0]        i_exp,
   input  logic [MANT_W-1:0]       i_mant,
   input  logic                    i_shift_flag,
   output logic                    o_valid,
   input  logic                    i_ready,
   output logic [EXP_W+MANT_W-1:0] o_result,
   output logic                    o_zero,
   output logic                    o_overflow
);

   typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

   localparam int RES_W = EXP_W + MANT_W;
   localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};
   localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};

   state_t              state_q, state_d;
   logic [MANT_W-1:0]   mant_q, mant_d;
   logic [EXP_W:0]      exp_q, exp_d;
   logic                sign_q, sign_d;
   logic [RES_W-1:0]    result_q, result_d;
   logic                zero_q, zero_d;
   logic                ovf_q, ovf_d;
   logic                valid_q, valid_d;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= IDLE;
         mant_q   <= '0;
         exp_q    <= '0;
         sign_q   <= 1'b0;
         result_q <= '0;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         mant_q   <= mant_d;
         exp_q    <= exp_d;
         sign_q   <= sign_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         ovf_q    <= ovf_d;
         valid_q  <= valid_d;
      end
   end

   // o_valid trails entry into DONE by one cycle, giving the k+2+n latency
   always_comb begin
      state_d  = state_q;
      mant_d   = mant_q;
      exp_d    = exp_q;
      sign_d   = sign_q;
      result_d = result_q;
      zero_d   = zero_q;
      ovf_d    = ovf_q;
      valid_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_valid) begin
               sign_d  = i_sign;
               exp_d   = {1'b0, i_exp} + {{EXP_W{1'b0}}, i_shift_flag};
               mant_d  = i_shift_flag ? {1'b1, i_mant[MANT_W-1:1]} : i_mant;
               state_d = NORM;
            end
         end
         NORM: begin
            if (exp_q >= EXP_MAX) begin
               result_d = {sign_q, {EXP_W{1'b1}}, {(MANT_W-1){1'b0}}};
               zero_d   = 1'b0;
               ovf_d    = 1'b1;
               state_d  = DONE;
            end else if (mant_q == '0) begin
               result_d = '0;
               zero_d   = 1'b1;
               ovf_d    = 1'b0;
               state_d  = DONE;
            end else if (mant_q[MANT_W-1]) begin
               result_d = {sign_q, exp_q[EXP_W-1:0], mant_q[MANT_W-2:0]};
               zero_d   = 1'b0;
               ovf_d    = 1'b0;
               state_d  = DONE;
            end else if (exp_q <= EXP_ONE) begin
               // exponent floor reached: emit a denormal without further shifting
               result_d = {sign_q, {EXP_W{1'b0}}, mant_q[MANT_W-2:0]};
               zero_d   = 1'b0;
               ovf_d    = 1'b0;
               state_d  = DONE;
            end else begin
               mant_d = {mant_q[MANT_W-2:0], 1'b0};
               exp_d  = exp_q - EXP_ONE;
            end
         end
         DONE: begin
            valid_d = 1'b1;
            if (valid_q && i_ready) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign o_ready    = (state_q == IDLE);
   assign o_valid    = valid_q;
   assign o_result   = result_q;
   assign o_zero     = zero_q;
   assign o_overflow = ovf_q;

endmodule

// File: doc/float_normalizer.md
Name: float_normalizer

Overview:
Post-add normalization stage of the single-precision floating adder. It sits directly downstream of the complement-adder stage and consumes its 24-bit magnitude result, overflow (shift) flag and sign, together with the aligned exponent. It renormalizes iteratively, one left shift per cycle, then packs an IEEE-754 single word. Valid/ready handshakes on both sides.

Parameters:
MANT_W, 24, mantissa width including the hidden bit.
EXP_W, 8, exponent field width; the all-ones value (255) is the overflow/infinity code.

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  asynchronous, active-high reset
i_valid  input  1  upstream result valid
o_ready  output  1  stage can accept; high only in IDLE
i_sign  input  1  result sign from the adder stage
i_exp  input  EXP_W  common (larger) exponent after alignment
i_mant  input  MANT_W  magnitude from the adder stage
i_shift_flag  input  1  same-sign carry-out; true magnitude is {1, i_mant}
o_valid  output  1  packed result valid
i_ready  input  1  downstream accepts result
o_result  output  32  {sign, exp[7:0], frac[22:0]}
o_zero  output  1  result is exact zero
o_overflow  output  1  result saturated to infinity

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, o_valid=0, o_result=0, o_zero=0, o_overflow=0, o_ready=1. Reset asserted mid-operation aborts it; the in-flight operand is discarded and no o_valid is produced.
- FSM states: IDLE, NORM, DONE.
- IDLE: o_ready=1. On i_valid&&o_ready, register the operand and go to NORM.
  - If i_shift_flag=1: mant_r={1'b1,i_mant[23:1]}, exp_r=i_exp+1. The dropped LSB is truncated.
  - Else: mant_r=i_mant, exp_r=i_exp.
  - exp_r is EXP_W+1 bits wide, so the +1 never wraps.
  - sign_r=i_sign.
- NORM: evaluates once per cycle in this priority order:
  1. exp_r>=255: overflow. Result {sign_r,8'hFF,23'h0}, o_overflow=1, go to DONE.
  2. mant_r==0: zero. Result 32'h0 with the sign forced to 0, o_zero=1, go to DONE.
  3. mant_r[23]==1: normalized. Result {sign_r,exp_r[7:0],mant_r[22:0]}, go to DONE.
  4. exp_r<=1: denormal. Result {sign_r,8'h00,mant_r[22:0]} with no further shift, go to DONE.
  5. Otherwise: mant_r<<=1, exp_r-=1, stay in NORM.
- DONE: o_valid=1. o_result, o_zero and o_overflow are held stable while i_ready=0. When o_valid&&i_ready, go to IDLE and clear o_valid.
- Latency is measured from the accept edge k, with n = number of left shifts (0..23):
  - o_valid rises at edge k+2+n.
  - Worst case is edge k+25.
  - An already-normalized, zero or overflow operand gives k+2.
- Throughput: one operation in flight. The next accept is possible in the cycle after the output handshake; there is no accept in DONE.
- Rounding: truncation toward zero. There are no guard/sticky bits at this stage.
- i_exp=255 at input is treated as overflow (infinity) through rule 1. NaN is not supported.
- Inputs are ignored outside IDLE. o_ready is a pure decode of state==IDLE.

Test Plan:
- Normalized pass-through: i_exp=127, i_mant=0x800000, i_shift_flag=0, i_sign=0 -> o_result=0x3F800000 (1.0), o_valid at k+2, flags 0.
- Carry overflow: i_exp=127, i_mant=0x000000, i_shift_flag=1 -> o_result=0x40000000 (2.0) at k+2.
- Massive cancellation: i_exp=127, i_mant=0x000001, i_sign=1 -> 23 shifts -> o_result=0xB4000000, o_valid at exactly k+25; o_ready low from k+1 to k+25.
- Zero and overflow:
  - i_mant=0, i_shift_flag=0, i_sign=1 -> o_result=0x00000000, o_zero=1.
  - i_exp=254, i_shift_flag=1, i_sign=1 -> o_result=0xFF800000, o_overflow=1.
- Denormal floor: i_exp=3, i_mant=0x100000 -> two shifts -> o_result=0x00400000, o_valid at k+4.
- Backpressure and reset:
  - Hold i_ready=0 for 10 cycles in DONE -> outputs stable, o_ready=0; single handshake on release, IDLE on the next cycle.
  - Assert i_rst at k+5 of the cancellation case -> o_valid never rises, all outputs 0, o_ready=1 after release.
